param_ram: RTL and testbench

//  Parametrised, double-buffered settings store for the pulse generator. UART-received bytes
//  are written into a staging bank by byte address. A commit request copies staging into an

---
 rtl/param_ram_pkg.sv | 16 +
 rtl/param_ram_cksum.sv | 40 ++++
 rtl/param_ram.sv | 172 +++++++++++++++++
 tb/tb_param_ram.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/param_ram_pkg.sv
// Shared types and constants for the double-buffered settings store.
// The checksum gate is enabled by defining RAM_CKSUM_EN.
package param_ram_pkg;

  localparam int unsigned NUM_WORDS_DEF      = 28;
  localparam int unsigned BYTES_PER_WORD_DEF = 4;
  localparam logic [7:0]  CKSUM_OK           = 8'h00;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StCopy,
    StDone
  } state_e;

endpackage

// File: rtl/param_ram_cksum.sv
// Byte-lane XOR accumulator, one word per cycle. result_o already includes word_i,
// so the final word's contribution is visible in the same cycle it is presented.
module param_ram_cksum #(
  parameter int unsigned BYTES_PER_WORD = 4,
  localparam int unsigned WORD_W = 8 * BYTES_PER_WORD
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [7:0]        result_o
);

  logic [7:0] acc_q, acc_d;
  logic [7:0] fold;

  always_comb begin
    fold = 8'h00;
    for (int b = 0; b < int'(BYTES_PER_WORD); b++) begin
      fold = fold ^ word_i[8*b +: 8];
    end
    result_o = acc_q ^ fold;
    acc_d    = acc_q;
    if (clr_i) begin
      acc_d = 8'h00;
    end else if (en_i) begin
      acc_d = result_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= 8'h00;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/param_ram.sv
// Double-buffered settings store: byte writes land in staging, commit copies to active.
// Define RAM_CKSUM_EN to gate each commit on a zero XOR over all staging bytes.
module param_ram
  import param_ram_pkg::*;
#(
  parameter int unsigned NUM_WORDS      = NUM_WORDS_DEF,
  parameter int unsigned BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  localparam int unsigned WORD_W  = 8 * BYTES_PER_WORD,
  localparam int unsigned ADDR_W  = $clog2(NUM_WORDS * BYTES_PER_WORD),
  localparam int unsigned RADDR_W = $clog2(NUM_WORDS)
) (
  input  logic               clk_RAM,
  input  logic               rst_RAM,
  input  logic [7:0]         in,
  input  logic [ADDR_W-1:0]  w_addr,
  input  logic               write,
  input  logic               commit,
  input  logic               rd_en,
  input  logic [RADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0]  rd_data,
  output logic               rd_valid,
  output logic [WORD_W-1:0]  ctrl_word,
  output logic               busy,
  output logic               commit_done,
  output logic               commit_err,
  output logic               wr_drop
);

  localparam logic [ADDR_W-1:0]  MaxByte  = ADDR_W'(NUM_WORDS * BYTES_PER_WORD - 1);
  localparam logic [RADDR_W-1:0] LastWord = RADDR_W'(NUM_WORDS - 1);

  state_e              state_q, state_d;
  logic [RADDR_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0]   stg_q [NUM_WORDS];
  logic [WORD_W-1:0]   stg_d [NUM_WORDS];
  logic [WORD_W-1:0]   act_q [NUM_WORDS];
  logic [WORD_W-1:0]   act_d [NUM_WORDS];
  logic [WORD_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_drop_q, wr_drop_d;

`ifdef RAM_CKSUM_EN
  logic       cks_clr, cks_en;
  logic [7:0] cks_result;

  param_ram_cksum #(
    .BYTES_PER_WORD(BYTES_PER_WORD)
  ) u_cksum (
    .clk_i   (clk_RAM),
    .rst_i   (rst_RAM),
    .clr_i   (cks_clr),
    .en_i    (cks_en),
    .word_i  (stg_q[idx_q]),
    .result_o(cks_result)
  );
`else
  assign commit_err = 1'b0;
`endif

  // Staging writes and the drop flag; writes are only legal while idle.
  always_comb begin
    stg_d     = stg_q;
    wr_drop_d = 1'b0;
    if (!write) begin
      if (state_q == StIdle && w_addr <= MaxByte) begin
        for (int w = 0; w < int'(NUM_WORDS); w++) begin
          for (int b = 0; b < int'(BYTES_PER_WORD); b++) begin
            if (w_addr == ADDR_W'(w * int'(BYTES_PER_WORD) + b)) begin
              stg_d[w][8*b +: 8] = in;
            end
          end
        end
      end else begin
        wr_drop_d = 1'b1;
      end
    end
  end

  always_comb begin
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      rd_data_d = (rd_addr <= LastWord) ? act_q[rd_addr] : '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    act_d       = act_q;
    commit_done = 1'b0;
`ifdef RAM_CKSUM_EN
    commit_err  = 1'b0;
    cks_clr     = 1'b0;
    cks_en      = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (commit) begin
          idx_d = '0;
`ifdef RAM_CKSUM_EN
          cks_clr = 1'b1;
          state_d = StCheck;
`else
          state_d = StCopy;
`endif
        end
      end
      StCheck: begin
`ifdef RAM_CKSUM_EN
        cks_en = 1'b1;
        if (idx_q == LastWord) begin
          idx_d = '0;
          if (cks_result == CKSUM_OK) begin
            state_d = StCopy;
          end else begin
            commit_err = 1'b1;
            state_d    = StIdle;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
`else
        state_d = StIdle;
`endif
      end
      StCopy: begin
        act_d[idx_q] = stg_q[idx_q];
        if (idx_q == LastWord) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        commit_done = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_RAM or posedge rst_RAM) begin
    if (rst_RAM) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      for (int w = 0; w < int'(NUM_WORDS); w++) begin
        stg_q[w] <= '0;
        act_q[w] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      wr_drop_q  <= wr_drop_d;
      stg_q      <= stg_d;
      act_q      <= act_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign wr_drop   = wr_drop_q;
  assign ctrl_word = act_q[0];
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_param_ram.sv
// Scoreboard bench for param_ram; read expectations are queued by stimulus and
// checked by an independent monitor. Covers the RAM_CKSUM_EN build when defined.
module tb_param_ram;

`ifdef RAM_CKSUM_EN
  localparam int CHK = 28;
`else
  localparam int CHK = 0;
`endif
  localparam int LAT = CHK + 29;

  logic        clk, rst, write, commit, rd_en;
  logic [7:0]  din;
  logic [6:0]  w_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data, ctrl_word;
  logic        rd_valid, busy, commit_done, commit_err, wr_drop;

  logic [31:0] exp_q[$];
  int          errors, checks;

  param_ram dut (
    .clk_RAM    (clk),
    .rst_RAM    (rst),
    .in         (din),
    .w_addr     (w_addr),
    .write      (write),
    .commit     (commit),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .ctrl_word  (ctrl_word),
    .busy       (busy),
    .commit_done(commit_done),
    .commit_err (commit_err),
    .wr_drop    (wr_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented read result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) chk("rd_spurious", {31'b0, rd_valid}, 32'd0);
      else chk("rd_data", rd_data, exp_q.pop_front());
    end
  end

  task automatic rd(input int addr, input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = 5'(addr);
    exp_q.push_back(exp);
    tick();
    rd_en = 1'b0;
    chk("rd_valid", {31'b0, rd_valid}, 32'd1);
  endtask

  task automatic wr(input int addr, input logic [7:0] b);
    write  = 1'b0;
    w_addr = 7'(addr);
    din    = b;
    tick();
    write = 1'b1;
  endtask

  task automatic commit_pulse();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  // Keeps the staging XOR at zero so the earlier scenarios also commit in the checksum build.
  task automatic fix(input logic [7:0] b);
`ifdef RAM_CKSUM_EN
    wr(111, b);
`else
    b = b;
`endif
  endtask

  task automatic wait_for(input bit err_sel, input int start_n, input int exp_n,
                          input string name);
    int n;
    n = start_n;
    while (!(err_sel ? commit_err : commit_done) && n < 200) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dn;
    errors = 0; checks = 0;
    rst = 1'b1; write = 1'b1; commit = 1'b0; rd_en = 1'b0;
    din = '0; w_addr = '0; rd_addr = '0;
    repeat (2) tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ctrl_word", ctrl_word, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_done_err_drop", {29'b0, commit_done, commit_err, wr_drop}, 32'd0);
    rst = 1'b0;

    // 1: all words read back zero, plus an out-of-range word address
    for (int i = 0; i < 28; i++) rd(i, 32'd0);
    rd(30, 32'd0);

    // 2: little-endian byte writes only become visible after commit
    wr(4, 8'h78); wr(5, 8'h56); wr(6, 8'h34); wr(7, 8'h12);
    chk("wr_drop_ok", {31'b0, wr_drop}, 32'd0);
    rd(1, 32'd0);
    fix(8'h08);
    commit_pulse();
    wait_for(1'b0, 1, LAT, "commit_latency");
    tick();
    rd(1, 32'h1234_5678);

    // 3: dropped writes and an ignored commit while busy
    wr(112, 8'hFF);
    chk("wr_drop_oob", {31'b0, wr_drop}, 32'd1);
    commit_pulse();
    wr(8, 8'hEE);
    chk("wr_drop_busy", {31'b0, wr_drop}, 32'd1);
    chk("busy_in_copy", {31'b0, busy}, 32'd1);
    commit_pulse();
    dn = 0;
    repeat (80) begin
      if (commit_done) dn++;
      tick();
    end
    chk("single_done", 32'(dn), 32'd1);
    chk("idle_after", {31'b0, busy}, 32'd0);
    rd(0, 32'd0);
    rd(2, 32'd0);
    rd(1, 32'h1234_5678);

    // 4: ctrl_word updates at the end of the i=0 copy cycle; a read in that cycle sees old data
    wr(0, 8'h01); wr(1, 8'h00); wr(2, 8'hA5); wr(3, 8'hA5);
    fix(8'h09);
    commit_pulse();
    repeat (CHK) tick();
    chk("ctrl_before_copy", ctrl_word, 32'd0);
    rd(0, 32'd0);
    chk("ctrl_after_copy0", ctrl_word, 32'hA5A5_0001);
    wait_for(1'b0, CHK + 2, LAT, "commit_latency2");
    tick();
    rd(0, 32'hA5A5_0001);

    // 6: asynchronous reset at copy index 10
    wr(20, 8'h77);
    fix(8'h7E);
    commit_pulse();
    repeat (CHK + 10) tick();
    chk("busy_mid_copy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_ctrl_word", ctrl_word, 32'd0);
    chk("arst_rd_data", rd_data, 32'd0);
    chk("arst_flags", {28'b0, rd_valid, commit_done, commit_err, wr_drop}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 28; i++) rd(i, 32'd0);

`ifdef RAM_CKSUM_EN
    // 5: bad checksum rejected, then fixed via the last byte
    wr(0, 8'h5A);
    commit_pulse();
    wait_for(1'b1, 1, 28, "cksum_err_latency");
    tick();
    rd(0, 32'd0);
    wr(111, 8'h5A);
    commit_pulse();
    wait_for(1'b0, 1, 57, "cksum_done_latency");
    tick();
    rd(0, 32'h0000_005A);
    rd(27, 32'h5A00_0000);
`endif

    repeat (3) tick();
    chk("rd_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
